// File: rtl/wb_regfile_if.sv
// Writeback and read-port bundle for the register file.
// The master side drives the MEM/WB writeback fields and the read addresses.
// The slave side (the register file) returns the read data.
interface wb_regfile_if;
    // Writeback fields from the MEM/WB pipeline register
    logic        regWrite;
    logic        memOrReg;
    logic        destOrPrivate;
    logic [3:0]  regDestAddress;
    logic [15:0] dataRes;
    logic [15:0] data;

    // Read addresses
    logic [2:0]  readAddr1;
    logic [2:0]  readAddr2;
    logic [1:0]  privAddr;

    // Read results
    logic [15:0] readData1;
    logic [15:0] readData2;
    logic [15:0] privData;
    logic [15:0] wbData;
    logic [15:0] sp;

    modport master (
        output regWrite, memOrReg, destOrPrivate, regDestAddress, dataRes, data,
        output readAddr1, readAddr2, privAddr,
        input  readData1, readData2, privData, wbData, sp
    );

    modport slave (
        input  regWrite, memOrReg, destOrPrivate, regDestAddress, dataRes, data,
        input  readAddr1, readAddr2, privAddr,
        output readData1, readData2, privData, wbData, sp
    );
endinterface

// File: rtl/wb_regfile.sv
// Register file for the writeback stage.
// It holds eight general registers R0-R7 and four private registers P0-P3.
// P0 is the stack pointer and resets to 16'h07FE.
// Reads are combinational.
// A write in progress is forwarded to any read port of the same bank that
// addresses the same register, so a read sees the new value in the write cycle.
module wb_regfile (
    input  logic         clk,
    input  logic         rst,
    wb_regfile_if.slave  bus
);
    localparam logic [15:0] SP_RESET = 16'h07FE;

    logic [15:0] genRegs  [8];
    logic [15:0] privRegs [4];

    logic [15:0] wbSel;
    logic        genWrite;
    logic        privWrite;
    logic [7:0]  genWe;
    logic [3:0]  privWe;

    // The upper destination bits are meaningless for the banks; this keeps them visibly sunk
    logic        unusedAddrBits;
    assign unusedAddrBits = bus.regDestAddress[3];

    // Writeback value select: load data or ALU result
    always_comb begin
        wbSel = bus.memOrReg ? bus.data : bus.dataRes;
    end

    assign genWrite  = bus.regWrite && !bus.destOrPrivate;
    assign privWrite = bus.regWrite &&  bus.destOrPrivate;

    // One-hot write enables; at most one register in either bank is selected
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : genDecode
            assign genWe[gi] = genWrite && (bus.regDestAddress[2:0] == 3'(gi));
        end
        for (gi = 0; gi < 4; gi++) begin : privDecode
            assign privWe[gi] = privWrite && (bus.regDestAddress[1:0] == 2'(gi));
        end
    endgenerate

    // Register array update; reset wins over any concurrent write
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) genRegs[i] <= '0;
            privRegs[0] <= SP_RESET;
            for (int i = 1; i < 4; i++) privRegs[i] <= '0;
        end else begin
            for (int i = 0; i < 8; i++) if (genWe[i])  genRegs[i]  <= wbSel;
            for (int i = 0; i < 4; i++) if (privWe[i]) privRegs[i] <= wbSel;
        end
    end

    // Read ports with same-bank write-through; bypass is suppressed during reset
    always_comb begin
        bus.wbData    = wbSel;
        bus.readData1 = genRegs[bus.readAddr1];
        bus.readData2 = genRegs[bus.readAddr2];
        bus.privData  = privRegs[bus.privAddr];
        bus.sp        = privRegs[0];
        if (!rst && genWrite) begin
            if (bus.readAddr1 == bus.regDestAddress[2:0]) bus.readData1 = wbSel;
            if (bus.readAddr2 == bus.regDestAddress[2:0]) bus.readData2 = wbSel;
        end
        if (!rst && privWrite) begin
            if (bus.privAddr == bus.regDestAddress[1:0]) bus.privData = wbSel;
            if (bus.regDestAddress[1:0] == 2'd0)         bus.sp       = wbSel;
        end
    end
endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile.
// A table of directed cycles exercises reset, writeback select, bypass,
// bank isolation, the stack pointer and address aliasing.
// A randomized run is then checked against a bank-level model of the
// register file.
module tb_wb_regfile;
    logic clk;
    logic rst;
    wb_regfile_if bus ();

    wb_regfile dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        we;
        logic        mor;
        logic        dop;
        logic [3:0]  dest;
        logic [15:0] res;
        logic [15:0] ld;
        logic [2:0]  ra1;
        logic [2:0]  ra2;
        logic [1:0]  pa;
        logic [15:0] eRd1;
        logic [15:0] eRd2;
        logic [15:0] ePriv;
        logic [15:0] eSp;
        logic [15:0] eWb;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    vec_t vecs [18];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic we, input logic mor, input logic dop,
                         input logic [3:0] dest, input logic [15:0] res, input logic [15:0] ld,
                         input logic [2:0] ra1, input logic [2:0] ra2, input logic [1:0] pa);
        rst                = r;
        bus.regWrite       = we;
        bus.memOrReg       = mor;
        bus.destOrPrivate  = dop;
        bus.regDestAddress = dest;
        bus.dataRes        = res;
        bus.data           = ld;
        bus.readAddr1      = ra1;
        bus.readAddr2      = ra2;
        bus.privAddr       = pa;
    endtask

    function automatic vec_t mk(input logic r, input logic we, input logic mor, input logic dop,
                                input logic [3:0] dest, input logic [15:0] res, input logic [15:0] ld,
                                input logic [2:0] ra1, input logic [2:0] ra2, input logic [1:0] pa,
                                input logic [15:0] e1, input logic [15:0] e2, input logic [15:0] ep,
                                input logic [15:0] es, input logic [15:0] ew);
        vec_t v;
        v.r = r; v.we = we; v.mor = mor; v.dop = dop; v.dest = dest; v.res = res; v.ld = ld;
        v.ra1 = ra1; v.ra2 = ra2; v.pa = pa;
        v.eRd1 = e1; v.eRd2 = e2; v.ePriv = ep; v.eSp = es; v.eWb = ew;
        return v;
    endfunction

    // Behavioural model: committed contents plus the contents after this edge
    logic [15:0] mGen [8];
    logic [15:0] mPriv [4];
    logic [15:0] nGen [8];
    logic [15:0] nPriv [4];

    initial begin
        //                r  we mor dop dest   res       ld        ra1 ra2 pa  rd1       rd2       priv      sp        wb
        // Reset held with a pending R3 write; the write must be dropped
        vecs[0]  = mk(1, 1, 0, 0, 4'd3, 16'hBEEF, 16'h0000, 3, 3, 0, 16'h0000, 16'h0000, 16'h07FE, 16'h07FE, 16'hBEEF);
        vecs[1]  = mk(1, 1, 0, 0, 4'd3, 16'hBEEF, 16'h0000, 3, 3, 0, 16'h0000, 16'h0000, 16'h07FE, 16'h07FE, 16'hBEEF);
        vecs[2]  = mk(0, 0, 0, 0, 4'd3, 16'hBEEF, 16'h0000, 3, 0, 0, 16'h0000, 16'h0000, 16'h07FE, 16'h07FE, 16'hBEEF);
        // Writeback select: load data into R5, ALU result into R6
        vecs[3]  = mk(0, 1, 1, 0, 4'd5, 16'hFFFF, 16'h1234, 5, 6, 1, 16'h1234, 16'h0000, 16'h0000, 16'h07FE, 16'h1234);
        vecs[4]  = mk(0, 1, 0, 0, 4'd6, 16'h00AA, 16'h1234, 5, 6, 1, 16'h1234, 16'h00AA, 16'h0000, 16'h07FE, 16'h00AA);
        vecs[5]  = mk(0, 0, 0, 0, 4'd0, 16'h0000, 16'h0000, 5, 6, 1, 16'h1234, 16'h00AA, 16'h0000, 16'h07FE, 16'h0000);
        // Dual bypass on R2, then registered value with the write disabled
        vecs[6]  = mk(0, 1, 0, 0, 4'd2, 16'h5A5A, 16'h0000, 2, 2, 2, 16'h5A5A, 16'h5A5A, 16'h0000, 16'h07FE, 16'h5A5A);
        vecs[7]  = mk(0, 0, 0, 0, 4'd2, 16'h1111, 16'h0000, 2, 2, 2, 16'h5A5A, 16'h5A5A, 16'h0000, 16'h07FE, 16'h1111);
        // Mid-stream reset: array contents are visible while reset is held
        vecs[8]  = mk(1, 0, 0, 0, 4'd2, 16'h1111, 16'h0000, 2, 2, 2, 16'h5A5A, 16'h5A5A, 16'h0000, 16'h07FE, 16'h1111);
        // Bank isolation: a P2 write does not reach general port 1 at address 2
        vecs[9]  = mk(0, 1, 0, 1, 4'd2, 16'h0042, 16'h0000, 2, 3, 2, 16'h0000, 16'h0000, 16'h0042, 16'h07FE, 16'h0042);
        vecs[10] = mk(0, 0, 0, 0, 4'd2, 16'h0000, 16'h0000, 2, 3, 2, 16'h0000, 16'h0000, 16'h0042, 16'h07FE, 16'h0000);
        // Stack pointer write with forwarding, then registered
        vecs[11] = mk(0, 1, 0, 1, 4'd0, 16'h07FC, 16'h0000, 0, 2, 0, 16'h0000, 16'h0000, 16'h07FC, 16'h07FC, 16'h07FC);
        vecs[12] = mk(0, 0, 0, 0, 4'd0, 16'h0000, 16'h0000, 0, 2, 0, 16'h0000, 16'h0000, 16'h07FC, 16'h07FC, 16'h0000);
        // Reset with a concurrent P0 write: no forwarding, and the write is dropped
        vecs[13] = mk(1, 1, 0, 1, 4'd0, 16'h1234, 16'h0000, 0, 2, 0, 16'h0000, 16'h0000, 16'h07FC, 16'h07FC, 16'h1234);
        vecs[14] = mk(0, 0, 0, 0, 4'd0, 16'h0000, 16'h0000, 0, 2, 0, 16'h0000, 16'h0000, 16'h07FE, 16'h07FE, 16'h0000);
        // Aliased address 4'b1111 lands in R7 and does not reach private P3
        vecs[15] = mk(0, 1, 0, 0, 4'hF, 16'hC0DE, 16'h0000, 7, 7, 3, 16'hC0DE, 16'hC0DE, 16'h0000, 16'h07FE, 16'hC0DE);
        vecs[16] = mk(0, 0, 0, 0, 4'hF, 16'hDEAD, 16'h0000, 7, 7, 3, 16'hC0DE, 16'hC0DE, 16'h0000, 16'h07FE, 16'hDEAD);
        vecs[17] = mk(0, 0, 0, 0, 4'hF, 16'hDEAD, 16'h0000, 7, 7, 3, 16'hC0DE, 16'hC0DE, 16'h0000, 16'h07FE, 16'hDEAD);

        // Initial reset so the register contents are defined
        drive(1, 0, 0, 0, 4'd0, 16'h0000, 16'h0000, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].r, vecs[i].we, vecs[i].mor, vecs[i].dop, vecs[i].dest,
                  vecs[i].res, vecs[i].ld, vecs[i].ra1, vecs[i].ra2, vecs[i].pa);
            @(negedge clk);
            $display("vec %0d: rst=%0d we=%0d dop=%0d dest=%h rd1=%h rd2=%h priv=%h sp=%h wb=%h",
                     i, vecs[i].r, vecs[i].we, vecs[i].dop, vecs[i].dest,
                     bus.readData1, bus.readData2, bus.privData, bus.sp, bus.wbData);
            chk("vec_readData1", bus.readData1, vecs[i].eRd1);
            chk("vec_readData2", bus.readData2, vecs[i].eRd2);
            chk("vec_privData",  bus.privData,  vecs[i].ePriv);
            chk("vec_sp",        bus.sp,        vecs[i].eSp);
            chk("vec_wbData",    bus.wbData,    vecs[i].eWb);
            @(posedge clk);
            #1;
        end

        // Bring the model and the DUT to a known state before random traffic
        drive(1, 0, 0, 0, 4'd0, 16'h0000, 16'h0000, 0, 0, 0);
        @(posedge clk);
        #1;
        for (int k = 0; k < 8; k++) mGen[k] = 16'h0000;
        for (int k = 0; k < 4; k++) mPriv[k] = (k == 0) ? 16'h07FE : 16'h0000;

        for (int t = 0; t < 300; t++) begin
            logic        r, we, mor, dop;
            logic [3:0]  dest;
            logic [15:0] res, ld, wb;
            logic [2:0]  ra1, ra2;
            logic [1:0]  pa;
            r    = ($urandom_range(0, 19) == 0);
            we   = ($urandom_range(0, 3) != 0);
            mor  = 1'($urandom);
            dop  = ($urandom_range(0, 2) == 0);
            dest = 4'($urandom);
            res  = 16'($urandom);
            ld   = 16'($urandom);
            ra1  = 3'($urandom);
            ra2  = ($urandom_range(0, 1) == 0) ? ra1 : 3'($urandom);
            pa   = 2'($urandom);
            drive(r, we, mor, dop, dest, res, ld, ra1, ra2, pa);

            // Contents the register file will hold after this edge if no reset occurs
            wb   = mor ? ld : res;
            nGen  = mGen;
            nPriv = mPriv;
            if (we) begin
                if (dop) nPriv[dest[1:0]] = wb;
                else     nGen[dest[2:0]]  = wb;
            end

            @(negedge clk);
            $display("rnd %0d: rst=%0d we=%0d dop=%0d dest=%h wb=%h rd1=%h rd2=%h priv=%h sp=%h",
                     t, r, we, dop, dest, bus.wbData, bus.readData1, bus.readData2, bus.privData, bus.sp);
            chk("rnd_wbData",    bus.wbData,    wb);
            chk("rnd_readData1", bus.readData1, r ? mGen[ra1]  : nGen[ra1]);
            chk("rnd_readData2", bus.readData2, r ? mGen[ra2]  : nGen[ra2]);
            chk("rnd_privData",  bus.privData,  r ? mPriv[pa]  : nPriv[pa]);
            chk("rnd_sp",        bus.sp,        r ? mPriv[0]   : nPriv[0]);
            @(posedge clk);
            #1;
            if (r) begin
                for (int k = 0; k < 8; k++) mGen[k] = 16'h0000;
                for (int k = 0; k < 4; k++) mPriv[k] = (k == 0) ? 16'h07FE : 16'h0000;
            end else begin
                mGen  = nGen;
                mPriv = nPriv;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset, named as follows.
  clk  in  1  rising-edge clock for all state.
  rst  in  1  synchronous active-high reset.
REQ-002 The module SHALL have these writeback inputs, driven by the MEM/WB pipeline register outputs.
  regWrite  in  1  write enable for this writeback.
  memOrReg  in  1  data select: 1 = data (memory load), 0 = dataRes (ALU result).
  destOrPrivate  in  1  target bank: 0 = general bank, 1 = private bank.
  regDestAddress  in  4  destination; general uses [2:0], private uses [1:0].
  dataRes  in  16  ALU result.
  data  in  16  memory load data.
REQ-003 The module SHALL have these read ports.
  readAddr1  in  3  general read port 1 address.
  readAddr2  in  3  general read port 2 address.
  privAddr  in  2  private read port address.
  readData1  out  16  general read port 1 data.
  readData2  out  16  general read port 2 data.
  privData  out  16  private read port data.
  wbData  out  16  selected writeback value.
  sp  out  16  private register P0, the stack pointer, always visible.

Function
REQ-004 The module SHALL hold 8 general registers R0-R7 (16 bits) and 4 private registers P0-P3 (16 bits); R0 is an ordinary writable register.
REQ-005 wbData SHALL equal data when memOrReg=1, else dataRes, combinationally.
REQ-006 On a clk rising edge with rst=0, regWrite=1, destOrPrivate=0, the module SHALL write wbData to R[regDestAddress[2:0]]; regDestAddress[3] is ignored.
REQ-007 On a clk rising edge with rst=0, regWrite=1, destOrPrivate=1, the module SHALL write wbData to P[regDestAddress[1:0]]; regDestAddress[3:2] are ignored.
REQ-008 With regWrite=0, no register SHALL change.
REQ-009 Exactly one register at most SHALL be written per cycle.
REQ-010 Read ports SHALL be combinational with zero latency.
REQ-011 Write-through bypass: when rst=0, regWrite=1, destOrPrivate=0 and readAddrN equals regDestAddress[2:0], readDataN SHALL equal wbData in the same cycle. Ports 1 and 2 are evaluated independently; both may bypass at once.
REQ-012 The equivalent bypass SHALL apply to privData and to sp (P0) for private-bank writes.
REQ-013 A general-bank write SHALL never bypass to a private port, and a private-bank write SHALL never bypass to a general port, even with equal low address bits.
REQ-014 A value written at edge N SHALL be read from the array (non-bypassed) in cycle N+1 onward.

Reset
REQ-015 At a clk rising edge with rst=1, R0-R7 and P1-P3 SHALL become 16'h0000, and P0 (sp) SHALL become 16'h07FE.
REQ-016 rst=1 SHALL take precedence over any concurrent write; the write SHALL be dropped, not deferred.
REQ-017 While rst=1, bypass SHALL be disabled and read ports SHALL show array contents.
REQ-018 Before the first reset edge, register contents SHALL be treated as undefined; the bench SHALL apply rst for at least 1 cycle first.
REQ-019 Reset asserted mid-stream SHALL clear state at that edge, and writes SHALL resume on the first edge with rst=0.

Verification
REQ-020 Reset: hold rst=1 for 2 cycles with regWrite=1, dest R3, dataRes=16'hBEEF -> after release, R3=0, readData1(addr 3)=0, sp=16'h07FE.
REQ-021 Writeback select: write R5 with memOrReg=1, data=16'h1234, dataRes=16'hFFFF; next cycle write R6 with memOrReg=0, dataRes=16'h00AA -> R5=16'h1234, R6=16'h00AA.
REQ-022 Bypass: regWrite=1, dest R2, dataRes=16'h5A5A, readAddr1=readAddr2=2 in the same cycle -> both readData=16'h5A5A before the edge; after the edge, with regWrite=0, both still read 16'h5A5A.
REQ-023 Bank isolation: private write P2=16'h0042 (regDestAddress=4'b0010, destOrPrivate=1) while readAddr1=2 -> readData1 unchanged (0); privData(addr 2)=16'h0042.
REQ-024 SP update: private write P0=16'h07FC -> sp=16'h07FC combinationally in the write cycle and registered after it; a following rst -> sp=16'h07FE.
REQ-025 Address aliasing and enable: general write with regDestAddress=4'b1111, dataRes=16'hC0DE -> R7=16'hC0DE; then regWrite=0 with another value at the same address -> R7 stays 16'hC0DE.
